// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: divider FSM states, widths and stall-source codes.
package mips_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Why the pipeline registers are being held; shared with the hazard unit
  typedef enum logic [1:0] {
    STALL_NONE      = 2'd0,
    STALL_DIV_START = 2'd1,
    STALL_DIV_MF    = 2'd2,
    STALL_LOAD_USE  = 2'd3
  } stall_src_e;

  // Stall source contributed by the divider; a new divide outranks an HI/LO read
  function automatic stall_src_e div_stall_src(input logic busy, input logic start,
                                               input logic mf_req);
    stall_src_e src;
    src = STALL_NONE;
    if (busy && start) begin
      src = STALL_DIV_START;
    end else if (busy && mf_req) begin
      src = STALL_DIV_MF;
    end
    return src;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider (purely combinational).
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  // Shifted partial remainder carries one extra bit so the compare never overflows
  logic [WIDTH:0] rem_sh;
  logic           ge;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs});

  // Subtract when the divisor fits; the result is < dvs so it fits in WIDTH bits
  always_comb begin
    rem_n = rem_sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], 1'b0};
    if (ge) begin
      rem_n    = rem_sh[WIDTH-1:0] - dvs;
      quo_n[0] = 1'b1;
    end
  end

endmodule

// File: rtl/mips_div_hilo_unit.sv
// Iterative DIV/DIVU engine with private HI/LO registers, placed beside the EX stage.
module mips_div_hilo_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             quo_sign_q, quo_sign_d;
  logic             rem_sign_q, rem_sign_d;
  logic             dvs_zero_q, dvs_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             dvd_neg;
  logic             dvs_neg;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem   (rem_q),
    .quo   (quo_q),
    .dvs   (dvs_q),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // Next-state: operand capture, one iteration per RUN cycle, sign fix-up into HI/LO
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    quo_sign_d = quo_sign_q;
    rem_sign_d = rem_sign_q;
    dvs_zero_d = dvs_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d    = DIV_RUN;
          count_d    = '0;
          rem_d      = '0;
          // Negating 0x80000000 wraps to itself, which is its correct unsigned magnitude
          quo_d      = dvd_neg ? -dividend : dividend;
          dvs_d      = dvs_neg ? -divisor : divisor;
          quo_sign_d = dvd_neg ^ dvs_neg;
          rem_sign_d = dvd_neg;
          dvs_zero_d = (divisor == '0);
        end
      end
      DIV_RUN: begin
        rem_d   = rem_n;
        quo_d   = quo_n;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d = DIV_IDLE;
        done_d  = 1'b1;
        // Divide by zero leaves |dividend| in rem; the remainder fix-up restores the raw operand
        hi_d    = rem_sign_q ? -rem_q : rem_q;
        if (dvs_zero_q) begin
          lo_d = '1;
        end else begin
          lo_d = quo_sign_q ? -quo_q : quo_q;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      quo_sign_q <= 1'b0;
      rem_sign_q <= 1'b0;
      dvs_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      quo_sign_q <= quo_sign_d;
      rem_sign_q <= rem_sign_d;
      dvs_zero_q <= dvs_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  // Status and read-out; HI/LO are visible directly from the registers
  always_comb begin
    busy  = (state_q != DIV_IDLE);
    done  = done_q;
    stall = (div_stall_src(busy, start, mf_req) != STALL_NONE);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_mips_div_hilo_unit.sv
// Directed self-checking bench for the iterative divider and its HI/LO registers.
module tb_mips_div_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mf_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;

  mips_div_hilo_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .mf_req    (mf_req),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a divide and wait (bounded) for done; lat counts the start edge as cycle 1
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcyc);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    bcyc  = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcyc++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcyc;
    int n;
    int done_cnt;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    start       = 1'b0;
    is_signed   = 1'b0;
    dividend    = '0;
    divisor     = '0;
    mf_req      = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b1;
    tick();

    // DIVU 100 / 7
    run_div(1'b0, 32'd100, 32'd7, lat, bcyc);
    check("divu_lat", lat, 32'd34);
    check("divu_busy_cycles", bcyc, 32'd33);
    check("divu_busy_at_done", {31'd0, busy}, 32'd0);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    tick();
    check("divu_done_pulse", {31'd0, done}, 32'd0);

    // DIV -100 / 7
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bcyc);
    check("div_neg_dvd_lat", lat, 32'd34);
    check("div_neg_dvd_hi", hi, 32'hFFFF_FFFE);
    check("div_neg_dvd_lo", lo, 32'hFFFF_FFF2);

    // DIV 100 / -7
    run_div(1'b1, 32'd100, 32'hFFFF_FFF9, lat, bcyc);
    check("div_neg_dvs_hi", hi, 32'd2);
    check("div_neg_dvs_lo", lo, 32'hFFFF_FFF2);

    // DIVU by zero
    run_div(1'b0, 32'h0000_1234, 32'd0, lat, bcyc);
    check("divu_zero_hi", hi, 32'h0000_1234);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);

    // DIV by zero with a negative dividend: no sign fix-up on LO
    run_div(1'b1, 32'hFFFF_FF9C, 32'd0, lat, bcyc);
    check("div_zero_hi", hi, 32'hFFFF_FF9C);
    check("div_zero_lo", lo, 32'hFFFF_FFFF);

    // Signed overflow
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_lo", lo, 32'h8000_0000);

    // MFHI/MFLO arriving mid-divide stalls and sees the old HI/LO
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mf_req = 1'b1;
    #1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      check("mf_stall", {31'd0, stall}, 32'd1);
      check("mf_hi_old", hi, 32'd0);
      check("mf_lo_old", lo, 32'h8000_0000);
      tick();
      n++;
    end
    check("mf_wait_cycles", n, 32'd29);
    check("mf_stall_done", {31'd0, stall}, 32'd0);
    check("mf_hi_new", hi, 32'd0);
    check("mf_lo_new", lo, 32'd100);
    mf_req = 1'b0;
    tick();

    // A start held through a busy divide is ignored, then accepted in the done cycle
    is_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    tick();
    dividend = 32'd77;
    divisor  = 32'd2;
    #1;
    check("busy_start_stall", {31'd0, stall}, 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("busy_start_lat", n, 32'd34);
    check("busy_start_stall_done", {31'd0, stall}, 32'd0);
    check("busy_start_hi", hi, 32'd0);
    check("busy_start_lo", lo, 32'd10);
    tick();
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("restart_lat", n, 32'd34);
    check("restart_hi", hi, 32'd1);
    check("restart_lo", lo, 32'd38);
    tick();

    // Reset mid-divide aborts at once and produces no done pulse
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    tick();
    rst      = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    check("post_rst_no_done", done_cnt, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
